// File: rtl/and_gate_dataflow.sv
// ---------------------------------------------------------------------------
// and_gate_dataflow
//
// Parameterised bitwise two-input AND unit. Provides a purely combinational
// result plus a registered, valid-qualified copy with reduction flags, a
// population count and a saturating counter of all-ones captures.
//
// Parameters:
//   WIDTH  operand/result width (WIDTH=1 makes y a plain 2-input AND gate)
//   CNT_W  width of the saturating match-event counter
//
// Ports:
//   clk         rising-edge clock for all registered outputs
//   rst         asynchronous active-high reset, clears all registered state
//   a, b        operands
//   in_valid    qualifies a/b for the registered path
//   y           combinational a & b (independent of clk, rst, in_valid)
//   y_q         registered a & b, captured when in_valid=1
//   out_valid   y_q holds a result captured on the previous edge
//   all_ones_q  registered reduction-AND of the captured result
//   any_one_q   registered reduction-OR of the captured result
//   pop_q       registered count of 1-bits in the captured result
//   match_cnt   number of all-ones captures, saturating at all-ones
// ---------------------------------------------------------------------------
module and_gate_dataflow #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8,
    // Popcount width; never narrower than one bit.
    localparam int POP_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_ones_q,
    output logic             any_one_q,
    output logic [POP_W-1:0] pop_q,
    output logic [CNT_W-1:0] match_cnt
);

    logic [WIDTH-1:0] w_y;
    logic             w_all_ones;
    logic             w_any_one;
    logic [POP_W-1:0] w_pop;
    logic             w_cnt_sat;

    // Running prefix sums of the set bits; the last entry is the popcount.
    logic [POP_W-1:0] w_psum [0:WIDTH];

    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic             r_all_ones;
    logic             r_any_one;
    logic [POP_W-1:0] r_pop;
    logic [CNT_W-1:0] r_match_cnt;

    // Pure dataflow path: standard AND semantics, so 0 & X resolves to 0.
    assign w_y        = a & b;
    assign w_all_ones = &w_y;
    assign w_any_one  = |w_y;

    assign w_psum[0] = '0;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pop
            assign w_psum[gi+1] = w_psum[gi] + POP_W'(w_y[gi]);
        end
    endgenerate
    assign w_pop = w_psum[WIDTH];

    // Counter stops at all-ones and never wraps.
    assign w_cnt_sat = &r_match_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
            r_all_ones  <= 1'b0;
            r_any_one   <= 1'b0;
            r_pop       <= '0;
            r_match_cnt <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y_q      <= w_y;
                r_all_ones <= w_all_ones;
                r_any_one  <= w_any_one;
                r_pop      <= w_pop;
                if (w_all_ones && !w_cnt_sat) begin
                    r_match_cnt <= r_match_cnt + 1'b1;
                end
            end
        end
    end

    assign y          = w_y;
    assign y_q        = r_y_q;
    assign out_valid  = r_out_valid;
    assign all_ones_q = r_all_ones;
    assign any_one_q  = r_any_one;
    assign pop_q      = r_pop;
    assign match_cnt  = r_match_cnt;

endmodule

// File: tb/tb_and_gate_dataflow.sv
module tb_and_gate_dataflow;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // WIDTH=4, CNT_W=8 instance and WIDTH=4, CNT_W=2 instance share inputs.
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       in_valid = 1'b0;

    logic [3:0] y4, yq4, yqs;
    logic       ov4, all4, any4, ovs, alls, anys;
    logic [2:0] pop4, pops;
    logic [7:0] cnt4;
    logic [1:0] cnts;

    // WIDTH=1 instance for the truth table.
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic [0:0] y1, yq1;
    logic       ov1, all1, any1;
    logic [0:0] pop1;
    logic [7:0] cnt1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    and_gate_dataflow #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .y(y4), .y_q(yq4), .out_valid(ov4), .all_ones_q(all4),
        .any_one_q(any4), .pop_q(pop4), .match_cnt(cnt4)
    );

    and_gate_dataflow #(.WIDTH(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .y(), .y_q(yqs), .out_valid(ovs), .all_ones_q(alls),
        .any_one_q(anys), .pop_q(pops), .match_cnt(cnts)
    );

    and_gate_dataflow #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(1'b0),
        .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones_q(all1),
        .any_one_q(any1), .pop_q(pop1), .match_cnt(cnt1)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    initial begin
        logic [3:0] tt_a [4];
        logic [3:0] tt_b [4];
        logic [3:0] tt_y [4];
        tt_a = '{4'd0, 4'd0, 4'd1, 4'd1};
        tt_b = '{4'd0, 4'd1, 4'd0, 4'd1};
        tt_y = '{4'd0, 4'd0, 4'd0, 4'd1};

        // Truth table on WIDTH=1 with no clock dependency, rst held high.
        for (int i = 0; i < 4; i++) begin
            a1 = tt_a[i][0:0];
            b1 = tt_b[i][0:0];
            #1;
            check_val($sformatf("tt%0d%0d", a1, b1), 32'(y1), 32'(tt_y[i]));
            #4;
        end

        // Reset state and combinational path during reset.
        a = 4'b1101; b = 4'b1011;
        #1;
        check_val("rst_y_q",     32'(yq4),  32'd0);
        check_val("rst_out_vld", 32'(ov4),  32'd0);
        check_val("rst_all",     32'(all4), 32'd0);
        check_val("rst_any",     32'(any4), 32'd0);
        check_val("rst_pop",     32'(pop4), 32'd0);
        check_val("rst_cnt",     32'(cnt4), 32'd0);
        check_val("rst_y_comb",  32'(y4),   32'h9);

        // Registered capture.
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        #1;
        check_val("cap_y_comb", 32'(y4), 32'h9);
        @(posedge clk); #1;
        check_val("cap_y_q",  32'(yq4),  32'h9);
        check_val("cap_pop",  32'(pop4), 32'd2);
        check_val("cap_any",  32'(any4), 32'd1);
        check_val("cap_all",  32'(all4), 32'd0);
        check_val("cap_ovld", 32'(ov4),  32'd1);
        check_val("cap_cnt",  32'(cnt4), 32'd0);

        // Hold with in_valid=0 while inputs change.
        @(negedge clk);
        in_valid = 1'b0;
        a = 4'hF; b = 4'h3;
        #1;
        check_val("hold_y_comb", 32'(y4), 32'h3);
        @(posedge clk); #1;
        check_val("hold_ovld", 32'(ov4),  32'd0);
        check_val("hold_y_q",  32'(yq4),  32'h9);
        check_val("hold_pop",  32'(pop4), 32'd2);

        // Zero result: any_one must drop, pop goes to 0.
        @(negedge clk);
        in_valid = 1'b1;
        a = 4'b1010; b = 4'b0101;
        @(posedge clk); #1;
        check_val("zero_y_q", 32'(yq4),  32'h0);
        check_val("zero_any", 32'(any4), 32'd0);
        check_val("zero_pop", 32'(pop4), 32'd0);

        // Reset pulse between edges, then all-ones captures.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a = 4'hF; b = 4'hF;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("sat_cnt_%0d", k), 32'(cnts),
                      (k < 3) ? 32'(k) : 32'd3);
            if (k == 3) begin
                check_val("ones_all", 32'(all4), 32'd1);
                check_val("ones_pop", 32'(pop4), 32'd4);
                check_val("ones_cnt", 32'(cnt4), 32'd3);
            end
        end

        // Asynchronous reset between edges with out_valid=1 and match_cnt=3.
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_y_q",  32'(yqs),  32'd0);
        check_val("arst_ovld", 32'(ovs),  32'd0);
        check_val("arst_all",  32'(alls), 32'd0);
        check_val("arst_any",  32'(anys), 32'd0);
        check_val("arst_pop",  32'(pops), 32'd0);
        check_val("arst_cnt",  32'(cnts), 32'd0);
        check_val("arst_cnt4", 32'(cnt4), 32'd0);
        check_val("arst_y",    32'(y4),   32'hF);

        // Capture on an edge while rst is high is discarded.
        @(posedge clk); #1;
        check_val("rst_edge_y_q", 32'(yq4), 32'd0);
        check_val("rst_edge_ovl", 32'(ov4), 32'd0);

        // First capture after release.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rel_y_q", 32'(yqs),  32'hF);
        check_val("rel_ovl", 32'(ovs),  32'd1);
        check_val("rel_cnt", 32'(cnts), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/and_gate_dataflow.md
Name: and_gate_dataflow

Overview:
- Parameterised bitwise two-input AND unit.
- Pure dataflow combinational path a & b, plus a registered, valid-qualified copy with reduction flags, population count and a saturating event counter.
- Used as a leaf logic primitive and as a registered AND stage in small datapaths.
- With WIDTH=1 the combinational output is exactly a 2-input AND gate.

Parameters:
- WIDTH, 1, bit width of operands a, b and result y.
- CNT_W, 8, width of the saturating match-event counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  asynchronous active-high reset; clears all registered state.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path.
- y  output  WIDTH  combinational a & b.
- y_q  output  WIDTH  registered a & b, captured when in_valid=1.
- out_valid  output  1  y_q holds a result captured on the previous edge.
- all_ones_q  output  1  registered reduction-AND of captured y.
- any_one_q  output  1  registered reduction-OR of captured y.
- pop_q  output  $clog2(WIDTH+1)  registered count of 1-bits in captured y; minimum width 1.
- match_cnt  output  CNT_W  count of captures where all bits of y were 1; saturating.

Behaviour:
- y = a & b, bitwise and continuous. No clock, reset or valid dependency.
- y settles in the same delta as any a/b change. X/Z inputs propagate per standard AND semantics (0 & X = 0).
- Reset (rst=1, asynchronous, immediate, held while high) forces:
  - y_q = 0, out_valid = 0, all_ones_q = 0, any_one_q = 0, pop_q = 0, match_cnt = 0.
  - y is unaffected by reset.
- Reset release takes effect synchronously: the first capture happens on the first rising clk edge with rst=0.
- Rising clk edge with in_valid=1:
  - y_q <= a & b.
  - all_ones_q <= &(a & b).
  - any_one_q <= |(a & b).
  - pop_q <= popcount(a & b).
  - out_valid <= 1.
  - If &(a & b) = 1 and match_cnt < 2^CNT_W-1, then match_cnt increments by 1.
- Rising clk edge with in_valid=0:
  - out_valid <= 0.
  - y_q, all_ones_q, any_one_q, pop_q and match_cnt hold their values.
- Latency: combinational path 0 cycles; registered path 1 cycle. Throughput is one result per clock. No backpressure.
- Saturation: match_cnt stops at all-ones and never wraps. Only reset clears it.
- Reset mid-operation: registered outputs clear immediately regardless of clk. A capture on the same edge that rst is asserted is discarded.

Test Plan:
- Truth table, WIDTH=1, no clock: (a,b) = 00, 01, 10, 11 at 5-time-unit steps -> y = 0, 0, 0, 1, each valid within the same time step.
- Registered capture, WIDTH=4: rst pulse, then in_valid=1, a=4'b1101, b=4'b1011 -> y=4'b1001 immediately. Next edge: y_q=4'b1001, pop_q=2, any_one_q=1, all_ones_q=0, out_valid=1.
- Hold: after a capture, drive in_valid=0 and change a/b -> y tracks the inputs; y_q and pop_q hold; out_valid=0 after the next edge.
- All-ones match: WIDTH=4, a=b=4'hF with in_valid=1 for 3 edges -> all_ones_q=1, pop_q=4, match_cnt=3.
- Saturation: CNT_W=2, 5 consecutive all-ones captures -> match_cnt sequence 1, 2, 3, 3, 3.
- Async reset: assert rst between clock edges while out_valid=1 and match_cnt=3 -> all registered outputs read 0 before the next edge. y still equals a & b.
